// File: rtl/opaque_fifo_pkg.sv
// Shared handshake package for the elastic buffer family (opaque_fifo, tehb).
// Contents:
//   fifo_clog2     - ceiling log2, used for count and pointer widths
//   fifo_ptr_width - pointer width, never less than one bit
//   hs_chan_t      - common valid/ready channel bundle for wrappers
package opaque_fifo_pkg;

    // Payload width of the shared channel bundle; wrappers with other widths
    // carry the payload beside the bundle.
    localparam int unsigned HS_DATA_W = 32;

    // Forward half of a valid/ready channel; ready travels the other way.
    typedef struct packed {
        logic                 valid;
        logic [HS_DATA_W-1:0] data;
    } hs_chan_t;

    // Ceiling log2; fifo_clog2(1) == 0.
    function automatic int unsigned fifo_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A depth-1 buffer still needs a one-bit pointer.
    function automatic int unsigned fifo_ptr_width(input int unsigned n);
        return (fifo_clog2(n) < 1) ? 1 : fifo_clog2(n);
    endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH pointer register. Advances by one when en_i is high and
// wraps from DEPTH-1 to 0 explicitly, so non-power-of-two depths work.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset, pointer returns to 0
//   en_i   - advance the pointer this cycle
//   ptr_o  - current pointer value
module fifo_ptr_wrap
    import opaque_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next pointer: hold, increment, or wrap at the last slot.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            if (ptr_q == PTR_W'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/opaque_fifo.sv
// Opaque elastic FIFO: a multi-slot valid/ready buffer whose outputs come
// from registered state only, so no input reaches an output combinationally.
// Placed after a tehb, the pair forms a fully decoupled pipeline cut.
// Ports:
//   clk        - clock
//   rst        - asynchronous active-low reset, discards all entries
//   ins        - input payload
//   ins_valid  - input valid
//   ins_ready  - input ready (not full)
//   outs       - output payload (head entry)
//   outs_valid - output valid (not empty)
//   outs_ready - output ready
//   occupancy  - entry count, only when OPAQUE_FIFO_OCC_EN is defined
module opaque_fifo
    import opaque_fifo_pkg::*;
#(
    parameter int unsigned DATA_TYPE = 32,
    parameter int unsigned NUM_SLOTS = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_TYPE-1:0]                 ins,
    input  logic                                 ins_valid,
    output logic                                 ins_ready,
`ifdef OPAQUE_FIFO_OCC_EN
    output logic [fifo_clog2(NUM_SLOTS+1)-1:0]   occupancy,
`endif
    output logic [DATA_TYPE-1:0]                 outs,
    output logic                                 outs_valid,
    input  logic                                 outs_ready
);

    localparam int unsigned CNT_W = fifo_clog2(NUM_SLOTS + 1);
    localparam int unsigned PTR_W = fifo_ptr_width(NUM_SLOTS);

    logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;

    // Status and handshakes; ins_ready and outs_valid look only at cnt_q.
    assign empty      = (cnt_q == '0);
    assign full       = (cnt_q == CNT_W'(NUM_SLOTS));
    assign ins_ready  = ~full;
    assign outs_valid = ~empty;
    assign push       = ins_valid & ins_ready;
    assign pop        = outs_valid & outs_ready;
    assign outs       = mem_q[rd_ptr];

    fifo_ptr_wrap #(
        .DEPTH (NUM_SLOTS),
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (push),
        .ptr_o  (wr_ptr)
    );

    fifo_ptr_wrap #(
        .DEPTH (NUM_SLOTS),
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (pop),
        .ptr_o  (rd_ptr)
    );

    // Count moves only when exactly one of push/pop happens.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Storage is cleared on reset so outs reads zero while empty after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr] <= ins;
        end
    end

`ifdef OPAQUE_FIFO_OCC_EN
    assign occupancy = cnt_q;
`endif

endmodule

// File: tb/tb_opaque_fifo.sv
// Self-checking bench for opaque_fifo with three instances:
// A (4 slots, 8 bit), B (3 slots, 8 bit), C (2 slots, 32 bit).
// Expected outputs are queued when a push is issued; per-instance monitors
// pop and compare whenever the DUT hands over a word.
module tb_opaque_fifo;

   logic clk;
   logic rst;

   logic [7:0]  insA, outsA;
   logic        validA, readyA, outValidA, outReadyA;
   logic [7:0]  insB, outsB;
   logic        validB, readyB, outValidB, outReadyB;
   logic [31:0] insC, outsC;
   logic        validC, readyC, outValidC, outReadyC;
`ifdef OPAQUE_FIFO_OCC_EN
   logic [2:0]  occA;
   logic [1:0]  occB;
   logic [1:0]  occC;
`endif

   logic [31:0] qA[$];
   logic [31:0] qB[$];
   logic [31:0] qC[$];
   logic [31:0] expA, expB, expC;
   int checks;
   int failures;
   int popCountC;

   opaque_fifo #(.DATA_TYPE(8), .NUM_SLOTS(4)) dutA (
      .clk(clk), .rst(rst), .ins(insA), .ins_valid(validA), .ins_ready(readyA),
`ifdef OPAQUE_FIFO_OCC_EN
      .occupancy(occA),
`endif
      .outs(outsA), .outs_valid(outValidA), .outs_ready(outReadyA));

   opaque_fifo #(.DATA_TYPE(8), .NUM_SLOTS(3)) dutB (
      .clk(clk), .rst(rst), .ins(insB), .ins_valid(validB), .ins_ready(readyB),
`ifdef OPAQUE_FIFO_OCC_EN
      .occupancy(occB),
`endif
      .outs(outsB), .outs_valid(outValidB), .outs_ready(outReadyB));

   opaque_fifo #(.DATA_TYPE(32), .NUM_SLOTS(2)) dutC (
      .clk(clk), .rst(rst), .ins(insC), .ins_valid(validC), .ins_ready(readyC),
`ifdef OPAQUE_FIFO_OCC_EN
      .occupancy(occC),
`endif
      .outs(outsC), .outs_valid(outValidC), .outs_ready(outReadyC));

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Waits for a DUT to hand over everything expected of it, bounded.
   task automatic applyStimulusDrain(input int which);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         case (which)
            0: done = (qA.size() == 0) && !outValidA;
            1: done = (qB.size() == 0) && !outValidB;
            default: done = (qC.size() == 0) && !outValidC;
         endcase
      end
      checkOutput("drain_done", 32'(done), 32'd1);
   endtask

   // Monitors: a transfer is decided by the values stable at the falling
   // edge, and completes at the following rising edge.
   always @(negedge clk) begin
      if (rst && outValidA && outReadyA) begin
         if (qA.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL a_unexpected actual=%0h expected=none", outsA);
         end else begin
            expA = qA.pop_front();
            checkOutput("a_data", 32'(outsA), expA);
         end
      end
   end

   always @(negedge clk) begin
      if (rst && outValidB && outReadyB) begin
         if (qB.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL b_unexpected actual=%0h expected=none", outsB);
         end else begin
            expB = qB.pop_front();
            checkOutput("b_data", 32'(outsB), expB);
         end
      end
   end

   always @(negedge clk) begin
      if (rst && outValidC && outReadyC) begin
         popCountC++;
         if (qC.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL c_unexpected actual=%0h expected=none", outsC);
         end else begin
            expC = qC.pop_front();
            checkOutput("c_data", outsC, expC);
         end
      end
   end

   // Watchdog so a stuck run still ends with a verdict.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed sequence.
   initial begin
      int stall;
      int occBad;
      int postRstValid;
      checks = 0; failures = 0; popCountC = 0;
      rst = 1'b0;
      insA = '0; validA = 0; outReadyA = 0;
      insB = '0; validB = 0; outReadyB = 0;
      insC = '0; validC = 0; outReadyC = 0;

      // Reset held for three cycles, then released.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_hold_valid", 32'(outValidA), 32'd0);
      checkOutput("rst_hold_ready", 32'(readyA), 32'd1);
      nextCycle();
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_outs", 32'(outsA), 32'h0);
      checkOutput("rst_valid", 32'(outValidA), 32'd0);
      checkOutput("rst_ready", 32'(readyA), 32'd1);
      checkOutput("rst_valid_c", 32'(outValidC), 32'd0);
      checkOutput("rst_outs_c", outsC, 32'h0);
`ifdef OPAQUE_FIFO_OCC_EN
      checkOutput("rst_occ", 32'(occA), 32'd0);
`endif
      nextCycle();

      // Fill A (4 slots) with A1..A4; A5 must then be refused.
      outReadyA = 0;
      for (int i = 0; i < 4; i++) begin
         insA = 8'hA1 + 8'(i); validA = 1;
         qA.push_back(32'hA1 + 32'(i));
         @(negedge clk);
         checkOutput("fill_ready", 32'(readyA), 32'd1);
         nextCycle();
      end
      insA = 8'hA5;
      @(negedge clk);
      checkOutput("full_ready", 32'(readyA), 32'd0);
      checkOutput("full_head", 32'(outsA), 32'hA1);
`ifdef OPAQUE_FIFO_OCC_EN
      checkOutput("full_occ", 32'(occA), 32'd4);
`endif
      nextCycle();
      @(negedge clk);
      checkOutput("full_ready_hold", 32'(readyA), 32'd0);
      checkOutput("full_head_hold", 32'(outsA), 32'hA1);
      nextCycle();
      validA = 0; outReadyA = 1;
      applyStimulusDrain(0);
      nextCycle();
      outReadyA = 0;

      // B (3 slots): push 1,2,3; pop two; push 4,5 (write pointer wraps); drain.
      for (int v = 1; v <= 3; v++) begin
         insB = 8'(v); validB = 1; qB.push_back(32'(v));
         @(negedge clk);
         checkOutput("b_push_ready", 32'(readyB), 32'd1);
         nextCycle();
      end
      validB = 0;
      @(negedge clk);
      checkOutput("b_full", 32'(readyB), 32'd0);
      nextCycle();
      outReadyB = 1;
      nextCycle();
      nextCycle();
      outReadyB = 0;
      for (int v = 4; v <= 5; v++) begin
         insB = 8'(v); validB = 1; qB.push_back(32'(v));
         @(negedge clk);
         checkOutput("b_push2_ready", 32'(readyB), 32'd1);
         nextCycle();
      end
      validB = 0;
      @(negedge clk);
      checkOutput("b_full2", 32'(readyB), 32'd0);
      checkOutput("b_head", 32'(outsB), 32'd3);
`ifdef OPAQUE_FIFO_OCC_EN
      checkOutput("b_occ", 32'(occB), 32'd3);
`endif
      nextCycle();
      outReadyB = 1;
      applyStimulusDrain(1);
      nextCycle();
      outReadyB = 0;

      // C (2 slots) streaming 0..99 with the consumer always ready.
      stall = 0; occBad = 0; popCountC = 0;
      outReadyC = 1; validC = 1;
      for (int i = 0; i < 100; i++) begin
         insC = 32'(i); qC.push_back(32'(i));
         @(negedge clk);
         if (!readyC) stall++;
`ifdef OPAQUE_FIFO_OCC_EN
         if (i > 0 && occC != 2'd1) occBad++;
`endif
         nextCycle();
      end
      validC = 0;
      @(negedge clk);
      nextCycle();
      checkOutput("stream_count", 32'(popCountC), 32'd100);
      checkOutput("stream_stalls", 32'(stall), 32'd0);
      checkOutput("stream_occ_bad", 32'(occBad), 32'd0);
      checkOutput("stream_empty", 32'(outValidC), 32'd0);

      // C full with a concurrent pop: the push waits one cycle.
      outReadyC = 0;
      insC = 32'h11; validC = 1; qC.push_back(32'h11);
      nextCycle();
      insC = 32'h22; qC.push_back(32'h22);
      nextCycle();
      insC = 32'h33; outReadyC = 1;
      @(negedge clk);
      checkOutput("c_full_pop_ready", 32'(readyC), 32'd0);
      checkOutput("c_full_pop_valid", 32'(outValidC), 32'd1);
      nextCycle();
      @(negedge clk);
      checkOutput("c_next_ready", 32'(readyC), 32'd1);
      qC.push_back(32'h33);
      nextCycle();
      validC = 0;
      applyStimulusDrain(2);
      nextCycle();
      outReadyC = 0;

      // Mid-operation asynchronous reset with three entries held in A.
      for (int v = 0; v < 3; v++) begin
         insA = 8'h51 + 8'(v); validA = 1;
         nextCycle();
      end
      validA = 0;
      @(negedge clk);
      checkOutput("held_valid", 32'(outValidA), 32'd1);
      nextCycle();
      #2 rst = 1'b0;
      #1;
      checkOutput("async_rst_valid", 32'(outValidA), 32'd0);
      checkOutput("async_rst_outs", 32'(outsA), 32'h0);
      checkOutput("async_rst_ready", 32'(readyA), 32'd1);
      @(posedge clk);
      #3 rst = 1'b1;
      nextCycle();
      outReadyA = 1;
      postRstValid = 0;
      repeat (4) begin
         @(negedge clk);
         if (outValidA) postRstValid++;
      end
      checkOutput("post_rst_empty", 32'(postRstValid), 32'd0);
      outReadyA = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
